somador_serial: RTL and testbench

- Parametrised digit-serial adder, the sequential successor to the single-bit full-adder cell.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first.
- Start/busy/done handshake; registered sum, carry-out and overflow flag.
- Used where area matters more than latency: shared arithmetic in slow control datapaths.

---
 rtl/somador_serial_pkg.sv | 23 ++
 rtl/somador_digito.sv | 28 ++
 rtl/somador_serial.sv | 136 +++++++++++++
 tb/tb_somador_serial.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/somador_serial_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and sizing/cell helpers.
package somador_serial_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Counter must stay at least one bit wide even when a single digit covers the word.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic fa_sum(input logic x, input logic y, input logic c);
      return x ^ y ^ c;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic c);
      return (x & y) | (x & c) | (y & c);
   endfunction

endpackage

// File: rtl/somador_digito.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
module somador_digito
   import somador_serial_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_top
);

   logic [DIGIT:0] c_s;

   assign c_s[0] = cin;

   for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign sum[gi]    = fa_sum(x[gi], y[gi], c_s[gi]);
      assign c_s[gi+1]  = fa_carry(x[gi], y[gi], c_s[gi]);
   end

   assign cout  = c_s[DIGIT];
   // Carry into the digit's MSB: on the last digit this is the carry into the sign bit.
   assign c_top = c_s[DIGIT-1];

endmodule

// File: rtl/somador_serial.sv
// Digit-serial adder: {co, s} = a + b + ci, DIGIT bits per clock, LSB digit first.
module somador_serial
   import somador_serial_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGIT  = 1,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ov
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(N);

   if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $fatal(1, "somador_serial: DIGIT must divide WIDTH exactly");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d, done_q, done_d, co_q, co_d, ov_q, ov_d;
   logic [DIGIT-1:0] dsum_s;
   logic             dcout_s, dctop_s, last_s;

   somador_digito #(.DIGIT(DIGIT)) u_digito (
      .x     (a_q[DIGIT-1:0]),
      .y     (b_q[DIGIT-1:0]),
      .cin   (carry_q),
      .sum   (dsum_s),
      .cout  (dcout_s),
      .c_top (dctop_s)
   );

   assign last_s = (cnt_q == CW'(N - 1));

   // Next-state, datapath shifting and result capture.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      co_d    = co_q;
      ov_d    = ov_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = ci;
               cnt_d   = {CW{1'b0}};
               busy_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            r_d     = r_q >> DIGIT;
            r_d[WIDTH-1 -: DIGIT] = dsum_s;
            carry_d = dcout_s;
            cnt_d   = cnt_q + CW'(1);
            // Outputs are written only here, so they never expose a partial sum.
            if (last_s) begin
               s_d     = r_d;
               co_d    = dcout_s;
               ov_d    = (SIGNED != 0) ? (dctop_s ^ dcout_s) : dcout_s;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any add in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         r_q     <= {WIDTH{1'b0}};
         s_q     <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign co   = co_q;
   assign ov   = ov_q;

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench: three adder configurations against an arithmetic reference model.
module tb_somador_serial;

   localparam int NI     = 3;
   localparam int DG [NI] = '{1, 1, 4};
   localparam int SG [NI] = '{0, 1, 0};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_s [NI];
   logic [7:0] a_s [NI];
   logic [7:0] b_s [NI];
   logic       ci_s [NI];
   logic       busy_s [NI];
   logic       done_s [NI];
   logic [7:0] s_s [NI];
   logic       co_s [NI];
   logic       ov_s [NI];

   logic [7:0] last_s [NI];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      somador_serial #(.WIDTH(8), .DIGIT(DG[gi]), .SIGNED(SG[gi])) u_dut (
         .clk   (clk),
         .rst   (rst),
         .start (start_s[gi]),
         .a     (a_s[gi]),
         .b     (b_s[gi]),
         .ci    (ci_s[gi]),
         .busy  (busy_s[gi]),
         .done  (done_s[gi]),
         .s     (s_s[gi]),
         .co    (co_s[gi]),
         .ov    (ov_s[gi])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_zero(input string tag, input int u);
      check({tag, "_busy"}, 32'(busy_s[u]), 32'd0);
      check({tag, "_done"}, 32'(done_s[u]), 32'd0);
      check({tag, "_s"},    32'(s_s[u]),    32'd0);
      check({tag, "_co"},   32'(co_s[u]),   32'd0);
      check({tag, "_ov"},   32'(ov_s[u]),   32'd0);
   endtask

   // Launch at a negedge (DUT idle or in DONE); returns at the negedge of the DONE cycle.
   task automatic add_op(input int u, input logic [7:0] av, input logic [7:0] bv,
                         input logic civ, input bit glitch);
      logic [8:0] exp9;
      logic       exp_ov;
      int         n, lat;
      bit         seen;
      exp9   = {1'b0, av} + {1'b0, bv} + {8'd0, civ};
      exp_ov = (SG[u] != 0) ? ((av[7] == bv[7]) && (exp9[7] != av[7])) : exp9[8];
      n      = 8 / DG[u];
      start_s[u] = 1'b1;
      a_s[u]     = av;
      b_s[u]     = bv;
      ci_s[u]    = civ;
      lat  = 0;
      seen = 1'b0;
      while (lat < 40 && !seen) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            start_s[u] = glitch;
            a_s[u]     = ~av;
            b_s[u]     = 8'h00;
            ci_s[u]    = ~civ;
         end else begin
            start_s[u] = 1'b0;
         end
         if (done_s[u] === 1'b1) seen = 1'b1;
         else check("busy_during_run", 32'(busy_s[u]), 32'd1);
      end
      check("done_seen", 32'(seen), 32'd1);
      check("latency",   32'(lat), 32'(n + 1));
      check("busy_in_done", 32'(busy_s[u]), 32'd0);
      check("sum",  32'(s_s[u]),  32'(exp9[7:0]));
      check("co",   32'(co_s[u]), 32'(exp9[8]));
      check("ov",   32'(ov_s[u]), 32'(exp_ov));
      last_s[u] = exp9[7:0];
   endtask

   task automatic idle_gap(input int u);
      @(negedge clk);
      check("done_one_cycle", 32'(done_s[u]), 32'd0);
      check("sum_held",       32'(s_s[u]),    32'(last_s[u]));
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         start_s[i] = 1'b1;
         a_s[i]     = 8'hAA;
         b_s[i]     = 8'h55;
         ci_s[i]    = 1'b1;
         last_s[i]  = 8'h00;
      end

      // Reset held for two cycles with start asserted.
      repeat (2) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) check_zero("reset", i);
      end
      for (int i = 0; i < NI; i++) start_s[i] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) check_zero("post_reset", i);

      // Unsigned, DIGIT=1.
      add_op(0, 8'h0F, 8'h01, 1'b0, 1'b0);
      idle_gap(0);
      add_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
      add_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0);
      idle_gap(0);

      // Signed overflow cases.
      add_op(1, 8'h7F, 8'h01, 1'b0, 1'b0);
      idle_gap(1);
      add_op(1, 8'h80, 8'hFF, 1'b0, 1'b0);
      idle_gap(1);
      add_op(1, 8'hFF, 8'h01, 1'b0, 1'b0);
      idle_gap(1);

      // DIGIT=4, including a start pulse while busy.
      add_op(2, 8'hA5, 8'h5A, 1'b1, 1'b0);
      idle_gap(2);
      add_op(2, 8'hA5, 8'h5A, 1'b1, 1'b1);
      idle_gap(2);

      // Randomized operands, mixing back-to-back and spaced starts.
      for (int u = 0; u < NI; u++) begin
         for (int k = 0; k < 15; k++) begin
            add_op(u, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 0) idle_gap(u);
         end
         idle_gap(u);
      end

      // Abort mid-operation on the DIGIT=1 unit.
      add_op(0, 8'h0F, 8'h01, 1'b0, 1'b0);
      idle_gap(0);
      start_s[0] = 1'b1;
      a_s[0]     = 8'h33;
      b_s[0]     = 8'h44;
      ci_s[0]    = 1'b0;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero("abort_now", 0);
      @(negedge clk);
      check_zero("abort_hold", 0);
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         check("no_done_after_abort", 32'(done_s[0]), 32'd0);
         check("idle_after_abort",    32'(busy_s[0]), 32'd0);
      end
      add_op(0, 8'h01, 8'h02, 1'b0, 1'b0);
      idle_gap(0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
